seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode 7-segment display (Basys3-class board).
- Latches a packed hex value and scans one digit per scan period.
- Decodes each nibble to active-low segments, with leading-zero blanking, per-digit blink and a one-cycle anti-ghosting blank between digits.
- Sits between game/score logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- SCAN_DIV, 100000, clk cycles per digit slot; legal range 2..2^20.
- BLINK_DIV, 64, full scan frames per blink half-period; legal range 1..1023.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe: capture value, dp_in, blink_mask.
- value  in  4*NUM_DIGITS  packed hex digits; digit i = value[4i+3:4i], digit 0 rightmost.
- dp_in  in  NUM_DIGITS  decimal-point request per digit, 1 = lit.
- blink_mask  in  NUM_DIGITS  1 = digit blinks.
- lz_en  in  1  leading-zero blanking enable; live, not latched.
- seg  out  7  active-low segments, seg[0]=a … seg[6]=g.
- dp  out  1  active-low decimal point.
- an  out  NUM_DIGITS  active-low anodes; at most one low at any time.
- frame  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - reset is synchronous and active-high, sampled only on the rising clk edge.
  - Reset has priority over load.
- Reset state:
  - an = all 1s, seg = 7'h7F, dp = 1, frame = 0.
  - Scan index = 0, prescaler = 0, blink frame counter = 0, blink phase = 0.
  - Latched value, dp and blink_mask registers = 0.
  - A reset asserted mid-scan or mid-blink returns all state to these values on the next edge.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - The tick is prescaler == SCAN_DIV-1.
  - On a tick, the scan index advances by 1 and wraps NUM_DIGITS-1 → 0.
  - With NUM_DIGITS = 1, the index stays 0.
- frame:
  - Asserted in the same cycle as the tick that wraps the index to 0.
  - Frame 0 after reset therefore ends at cycle NUM_DIGITS*SCAN_DIV.
- Blink:
  - On each frame, the blink counter increments.
  - At BLINK_DIV-1 the counter clears and the blink phase toggles.
- Outputs:
  - All outputs are registered and computed from the current index and the latched registers.
  - Anti-ghost: in the cycle where prescaler == 0, an = all 1s, seg = 7'h7F and dp = 1.
  - Otherwise an[idx] = 0 and all other an bits = 1.
- Decode (active-low, hex 0..F):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Blanking: seg = 7'h7F and dp = 1 while an[idx] stays low, when either condition holds:
  - lz_en = 1, idx ≠ 0, and every latched nibble from idx to NUM_DIGITS-1 is 0.
  - blink phase = 1 and latched blink_mask[idx] = 1.
- dp when not blanked: dp = ~latched_dp[idx].
- load:
  - Registers take effect on the next edge.
  - The new data is visible on the outputs 2 cycles after the load edge, i.e. on the next output register update.
  - load does not disturb the scan, prescaler or blink counters.
  - Back-to-back loads: the last one wins.
- Value 0 with lz_en = 1: digit 0 still shows "0".

Test Plan:
- NUM_DIGITS=4, SCAN_DIV=4, reset held 3 cycles → an=4'hF, seg=7'h7F, dp=1 throughout reset. After release, the anode sequence per slot is [F,E,E,E],[F,D,D,D],[F,B,B,B],[F,7,7,7], and frame pulses in cycle 16.
- load value=16'h1A3F, lz_en=0 → segs per digit 0..3 = 0E, 30, 08, 79. Sweep value through 0..F in digit 0 and check all 16 decode codes.
- value=16'h0050, lz_en=1 → digits 3 and 2 blanked (7F), digit 1 = 12, digit 0 = 40. With value=0, only digit 0 shows 40.
- BLINK_DIV=2, blink_mask=4'b0010, value=16'h8888 → digit 1 shows 00 for 2 frames, then 7F for 2 frames, repeating. Other digits are steady 00, and an[1] still pulses low.
- dp_in=4'b0100 → dp=0 only while an=4'hB and not in anti-ghost cycles.
- Assert reset in the middle of slot 2 with blink phase=1 → next cycle is the full reset state, and the scan restarts from digit 0 with latched value=0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// A packed hex value is captured on a load strobe. The digits are then scanned
// one per slot of SCAN_DIV clocks. Each nibble is decoded to active-low
// segments, with optional leading-zero blanking and per-digit blink. The first
// clock of every slot is fully dark, so the previous digit's segments never
// ghost onto the next anode.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   load        one-cycle strobe: capture value, dp_in, blink_mask
//   value       packed hex digits, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_in       decimal-point request per digit (1 = lit)
//   blink_mask  per-digit blink enable (1 = blinks)
//   lz_en       leading-zero blanking enable (live input, not latched)
//   seg         active-low segments, seg[0] = a ... seg[6] = g
//   dp          active-low decimal point
//   an          active-low anodes, at most one low at a time
//   frame       one-cycle pulse when the scan wraps from the last digit to 0
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int BLINK_DIV  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);

    // Counter widths are clamped to 1 so degenerate parameter values
    // (one digit, blink every frame) still give legal vectors.
    localparam int PSC_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;

    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    // Hex nibble to active-low segment pattern (bit 0 = a ... bit 6 = g).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // True when every nibble from position 'pos' up to the most significant
    // digit is zero, i.e. the digit at 'pos' is a leading zero.
    function automatic logic upper_all_zero(input logic [4*NUM_DIGITS-1:0] v,
                                            input logic [IDX_W-1:0]        pos);
        logic z;
        z = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((IDX_W'(j) >= pos) && (v[4*j +: 4] != 4'h0)) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

    // Stage p0: scan timing, blink timing and latched display data
    logic [PSC_W-1:0]        psc_p0;
    logic [IDX_W-1:0]        idx_p0;
    logic [BLK_W-1:0]        bcnt_p0;
    logic                    phase_p0;
    logic [4*NUM_DIGITS-1:0] val_p0;
    logic [NUM_DIGITS-1:0]   dpl_p0;
    logic [NUM_DIGITS-1:0]   blk_p0;

    logic tick;
    logic wrap;

    assign tick = (psc_p0 == PSC_LAST);
    assign wrap = tick && (idx_p0 == IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            psc_p0 <= '0;
            idx_p0 <= '0;
        end else begin
            if (tick) begin
                psc_p0 <= '0;
                idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
            end else begin
                psc_p0 <= psc_p0 + PSC_W'(1);
            end
        end
    end

    // Blink phase flips once every BLINK_DIV complete frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt_p0  <= '0;
            phase_p0 <= 1'b0;
        end else if (wrap) begin
            if (bcnt_p0 == BLK_LAST) begin
                bcnt_p0  <= '0;
                phase_p0 <= ~phase_p0;
            end else begin
                bcnt_p0 <= bcnt_p0 + BLK_W'(1);
            end
        end
    end

    // Display data is cleared by reset as well, so a reset display reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            val_p0 <= '0;
            dpl_p0 <= '0;
            blk_p0 <= '0;
        end else if (load) begin
            val_p0 <= value;
            dpl_p0 <= dp_in;
            blk_p0 <= blink_mask;
        end
    end

    // Next output values, derived from the current scan position
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blink;
    logic                  lz_blank;
    logic                  blink_blank;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (idx_p0 == IDX_W'(j)) begin
                cur_nib   = val_p0[4*j +: 4];
                cur_dp    = dpl_p0[j];
                cur_blink = blk_p0[j];
            end
        end

        // Digit 0 is never a leading zero, so a zero value still shows "0".
        lz_blank    = lz_en && (idx_p0 != '0) && upper_all_zero(val_p0, idx_p0);
        blink_blank = phase_p0 && cur_blink;

        an_nxt  = '1;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;

        // Slot position 0 is the dark anti-ghost cycle.
        if (psc_p0 != '0) begin
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if (idx_p0 == IDX_W'(j)) begin
                    an_nxt[j] = 1'b0;
                end
            end
            // A blanked digit keeps its anode low so the scan duty stays even.
            if (!(lz_blank || blink_blank)) begin
                seg_nxt = hex_to_seg(cur_nib);
                dp_nxt  = ~cur_dp;
            end
        end
    end

    // Stage p1: registered board outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            an    <= '1;
            seg   <= 7'h7F;
            dp    <= 1'b1;
            frame <= 1'b0;
        end else begin
            an    <= an_nxt;
            seg   <= seg_nxt;
            dp    <= dp_nxt;
            frame <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=4,
// BLINK_DIV=2. Each frame step pushes the expected per-cycle display state to
// a scoreboard queue. Entries are then popped and compared, one per clock.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    seg7_scan_driver #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (4),
        .BLINK_DIV (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .blink_mask(blink_mask),
        .lz_en     (lz_en),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame     (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } exp_t;

    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Loads queued for the tail of the frame currently being checked.
    logic        pre_armed = 1'b0;
    logic [15:0] pre_value;
    logic [3:0]  pre_dp;
    logic [3:0]  pre_blink;
    logic        nxt_armed = 1'b0;
    logic [15:0] nxt_value;
    logic [3:0]  nxt_dp;
    logic [3:0]  nxt_blink;
    logic        nxt_lz;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, " an"},    {3'b000, an},      {3'b000, e.an});
            chk({e.tag, " seg"},   seg,               e.seg);
            chk({e.tag, " dp"},    {6'b000000, dp},    {6'b000000, e.dp});
            chk({e.tag, " frame"}, {6'b000000, frame}, {6'b000000, e.frame});
        end
    endtask

    task automatic reset_cycle(input string tag);
        exp_t e;
        e.tag = tag; e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.frame = 1'b0;
        sb.push_back(e);
        check_cycle();
    endtask

    task automatic arm(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                       input logic lz);
        nxt_armed = 1'b1; nxt_value = v; nxt_dp = d; nxt_blink = b; nxt_lz = lz;
    endtask

    task automatic arm_pre(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        pre_armed = 1'b1; pre_value = v; pre_dp = d; pre_blink = b;
    endtask

    // Checks 'ncyc' cycles of one scan frame. segs[i] is the expected pattern
    // of digit i, and dpm has a 1 where a lit decimal point is expected.
    // Armed loads are applied in the final two cycles, while the upcoming
    // anti-ghost slot hides them.
    task automatic run_frame(input string tag, input logic [3:0][6:0] segs,
                             input logic [3:0] dpm, input int ncyc);
        exp_t e;
        for (int p = 0; p < ncyc; p++) begin
            int s;
            int q;
            s = p / 4;
            q = p % 4;
            e.tag   = $sformatf("%s_p%0d", tag, p);
            e.an    = (q == 0) ? 4'hF : ~(4'b0001 << s);
            e.seg   = (q == 0) ? 7'h7F : segs[s];
            e.dp    = (q == 0) ? 1'b1 : ~dpm[s];
            e.frame = (p == 15);
            sb.push_back(e);
        end
        for (int p = 0; p < ncyc; p++) begin
            check_cycle();
            load = 1'b0;
            if (p == 14 && pre_armed) begin
                load = 1'b1; value = pre_value; dp_in = pre_dp; blink_mask = pre_blink;
                pre_armed = 1'b0;
            end
            if (p == 15 && nxt_armed) begin
                load = 1'b1; value = nxt_value; dp_in = nxt_dp; blink_mask = nxt_blink;
                lz_en = nxt_lz;
                nxt_armed = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; load = 1'b0; value = 16'h0000; dp_in = 4'h0;
        blink_mask = 4'h0; lz_en = 1'b0;

        // Reset held for three cycles.
        repeat (3) reset_cycle("rst_hold");
        reset = 1'b0;

        // First frame after reset: value 0, no blanking, frame pulse in cycle 16.
        arm(16'h1A3F, 4'h0, 4'h0, 1'b0);
        run_frame("frame0", {7'h40, 7'h40, 7'h40, 7'h40}, 4'h0, 16);

        arm(16'h0000, 4'h0, 4'h0, 1'b0);
        run_frame("hex_1a3f", {7'h79, 7'h08, 7'h30, 7'h0E}, 4'h0, 16);

        // Sweep all 16 codes through digit 0.
        for (int d = 0; d < 16; d++) begin
            if (d < 15) arm(16'(d + 1), 4'h0, 4'h0, 1'b0);
            else        arm(16'h0050, 4'h0, 4'h0, 1'b1);
            run_frame($sformatf("dec_%0h", d), {7'h40, 7'h40, 7'h40, seg_tab[d]}, 4'h0, 16);
        end

        // Leading-zero blanking.
        arm(16'h0000, 4'h0, 4'h0, 1'b1);
        run_frame("lz_0050", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'h0, 16);

        // Back-to-back loads: the decoy must be overwritten by the second.
        arm_pre(16'hFFFF, 4'hF, 4'hF);
        arm(16'h1A3F, 4'b0100, 4'h0, 1'b0);
        run_frame("lz_zero", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'h0, 16);

        arm(16'h8888, 4'h0, 4'b0010, 1'b0);
        run_frame("dp_2", {7'h79, 7'h08, 7'h30, 7'h0E}, 4'b0100, 16);

        // Blink on digit 1. The phase flips after every second frame.
        run_frame("blink_a", {7'h00, 7'h00, 7'h00, 7'h00}, 4'h0, 16);
        run_frame("blink_b", {7'h00, 7'h00, 7'h7F, 7'h00}, 4'h0, 16);
        run_frame("blink_c", {7'h00, 7'h00, 7'h7F, 7'h00}, 4'h0, 16);
        run_frame("blink_d", {7'h00, 7'h00, 7'h00, 7'h00}, 4'h0, 16);
        run_frame("blink_e", {7'h00, 7'h00, 7'h00, 7'h00}, 4'h0, 16);
        run_frame("blink_f", {7'h00, 7'h00, 7'h7F, 7'h00}, 4'h0, 16);

        // Reset in the middle of slot 2 while the blink phase is 1. A load
        // issued in the same cycle must lose to reset.
        run_frame("pre_rst", {7'h00, 7'h00, 7'h7F, 7'h00}, 4'h0, 10);
        reset = 1'b1; load = 1'b1; value = 16'hFFFF; dp_in = 4'hF; blink_mask = 4'hF;
        reset_cycle("mid_rst0");
        load = 1'b0;
        reset_cycle("mid_rst1");
        reset = 1'b0;

        arm(16'h8888, 4'h0, 4'b0010, 1'b0);
        run_frame("post_rst", {7'h40, 7'h40, 7'h40, 7'h40}, 4'h0, 16);
        run_frame("post_blink_on", {7'h00, 7'h00, 7'h00, 7'h00}, 4'h0, 16);
        run_frame("post_blink_off", {7'h00, 7'h00, 7'h7F, 7'h00}, 4'h0, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
